// File: rtl/ks_seq_ctrl.sv
// Sequential Karatsuba controller: one external WxW carry-less core is time-shared over three cycles to form a 2Wx2W product.
// Optional define KS_SEQ_OVERLAP_EN lets a new operand pair be accepted on the same edge as the result handoff.
module ks_seq_ctrl #(
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [2*W-1:0] in_a,
   input  logic [2*W-1:0] in_b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [4*W-2:0] out_d,
   output logic [W-1:0]   mul_a,
   output logic [W-1:0]   mul_b,
   input  logic [2*W-2:0] mul_d,
   output logic           busy
);

   typedef enum logic [2:0] {IDLE, LO, HI, MID, DONE} state_t;

   state_t         state;
   state_t         state_next;
   logic [2*W-1:0] a_r;
   logic [2*W-1:0] b_r;
   logic [2*W-2:0] m_lo;
   logic [2*W-2:0] m_hi;
   logic [2*W-2:0] mid_sum;
   logic [4*W-2:0] product;
   logic           accept;

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      mul_a      = '0;
      mul_b      = '0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_next = LO;
         end
         LO: begin
            mul_a      = a_r[W-1:0];
            mul_b      = b_r[W-1:0];
            state_next = HI;
         end
         HI: begin
            mul_a      = a_r[2*W-1:W];
            mul_b      = b_r[2*W-1:W];
            state_next = MID;
         end
         MID: begin
            mul_a      = a_r[2*W-1:W] ^ a_r[W-1:0];
            mul_b      = b_r[2*W-1:W] ^ b_r[W-1:0];
            state_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
`ifdef KS_SEQ_OVERLAP_EN
            in_ready = out_ready;
            if (out_ready) state_next = in_valid ? LO : IDLE;
`else
            if (out_ready) state_next = IDLE;
`endif
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy   = (state != IDLE);
   assign accept = in_valid & in_ready;

   // The middle product is taken straight off the core while in MID, so it never needs its own register.
   assign mid_sum = m_lo ^ m_hi ^ mul_d;
   assign product = {{(2*W){1'b0}}, m_lo}
                  ^ {{W{1'b0}}, mid_sum, {W{1'b0}}}
                  ^ {m_hi, {(2*W){1'b0}}};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         a_r   <= '0;
         b_r   <= '0;
         m_lo  <= '0;
         m_hi  <= '0;
         out_d <= '0;
      end else begin
         state <= state_next;
         if (accept) begin
            a_r <= in_a;
            b_r <= in_b;
         end
         if (state == LO) m_lo <= mul_d;
         if (state == HI) m_hi <= mul_d;
         if (state == MID) out_d <= product;
      end
   end

endmodule
